// File: rtl/multicycle_control_unit.sv
// Main control FSM for the multicycle MIPS datapath.
// Sequences fetch/decode/execute/memory/writeback and drives the datapath
// selects, write enables and the 3-bit aluop for alu_control_unit.
// Optional: define IMM_LOGIC_EN to add andi/ori support via IMMEX.
module multicycle_control_unit #(
   parameter logic [1:0] PC_INC_SEL = 2'b01,
   parameter int         STATE_W    = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [5:0]         opcode,
   input  logic               zero,
   input  logic               mem_ready,
   output logic               mem_req,
   output logic               mem_write,
   output logic               iord,
   output logic               ir_write,
   output logic               pc_write,
   output logic               reg_write,
   output logic               regdst,
   output logic               memtoreg,
   output logic               alusrca,
   output logic [1:0]         alusrcb,
   output logic [1:0]         pcsrc,
   output logic [2:0]         aluop,
   output logic               illegal_op,
   output logic [STATE_W-1:0] state
);

   typedef enum logic [STATE_W-1:0] {
      S_FETCH  = 0,  S_DECODE = 1,  S_MEMADR = 2,  S_MEMRD = 3,
      S_MEMWB  = 4,  S_MEMWR  = 5,  S_RTEX   = 6,  S_ALUWB = 7,
      S_BRANCH = 8,  S_ADDIEX = 9,  S_IMMEX  = 10, S_JUMP  = 11,
      S_IMMWB  = 12
   } state_t;

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_J     = 6'h02;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ADDI  = 6'h08;
   localparam logic [5:0] OP_ANDI  = 6'h0C;
   localparam logic [5:0] OP_ORI   = 6'h0D;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2B;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_R   = 3'b010;
   localparam logic [2:0] ALU_AND = 3'b011;
   localparam logic [2:0] ALU_OR  = 3'b100;

   state_t state_q, state_d;

   assign state = state_q;

   // State register; reset drops straight back to FETCH, abandoning any access.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state_q <= S_FETCH;
      else     state_q <= state_d;
   end

   // Next-state and output decode; every output defaults to 0 per state.
   always_comb begin
      state_d    = state_q;
      mem_req    = 1'b0;
      mem_write  = 1'b0;
      iord       = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      reg_write  = 1'b0;
      regdst     = 1'b0;
      memtoreg   = 1'b0;
      alusrca    = 1'b0;
      alusrcb    = 2'b00;
      pcsrc      = 2'b00;
      aluop      = ALU_ADD;
      illegal_op = 1'b0;
      case (state_q)
         S_FETCH: begin
            // IR capture and PC+4 happen together on the completing cycle;
            // gated by rst so nothing loads while reset is held.
            mem_req  = 1'b1;
            alusrcb  = PC_INC_SEL;
            ir_write = mem_ready & ~rst;
            pc_write = mem_ready & ~rst;
            if (mem_ready) state_d = S_DECODE;
         end
         S_DECODE: begin
            alusrcb = 2'b11;
            case (opcode)
               OP_LW, OP_SW: state_d = S_MEMADR;
               OP_RTYPE:     state_d = S_RTEX;
               OP_BEQ:       state_d = S_BRANCH;
               OP_ADDI:      state_d = S_ADDIEX;
               OP_J:         state_d = S_JUMP;
`ifdef IMM_LOGIC_EN
               OP_ANDI, OP_ORI: state_d = S_IMMEX;
`endif
               default: begin
                  illegal_op = 1'b1;
                  state_d    = S_FETCH;
               end
            endcase
         end
         S_MEMADR: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = (opcode == OP_SW) ? S_MEMWR : S_MEMRD;
         end
         S_MEMRD: begin
            mem_req = 1'b1;
            iord    = 1'b1;
            if (mem_ready) state_d = S_MEMWB;
         end
         S_MEMWB: begin
            reg_write = 1'b1;
            memtoreg  = 1'b1;
            state_d   = S_FETCH;
         end
         S_MEMWR: begin
            mem_req   = 1'b1;
            mem_write = 1'b1;
            iord      = 1'b1;
            if (mem_ready) state_d = S_FETCH;
         end
         S_RTEX: begin
            alusrca = 1'b1;
            aluop   = ALU_R;
            state_d = S_ALUWB;
         end
         S_ALUWB: begin
            reg_write = 1'b1;
            regdst    = 1'b1;
            state_d   = S_FETCH;
         end
         S_BRANCH: begin
            alusrca  = 1'b1;
            aluop    = ALU_SUB;
            pcsrc    = 2'b01;
            pc_write = zero;
            state_d  = S_FETCH;
         end
         S_ADDIEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            state_d = S_IMMWB;
         end
`ifdef IMM_LOGIC_EN
         S_IMMEX: begin
            alusrca = 1'b1;
            alusrcb = 2'b10;
            aluop   = (opcode == OP_ORI) ? ALU_OR : ALU_AND;
            state_d = S_IMMWB;
         end
`endif
         S_IMMWB: begin
            reg_write = 1'b1;
            state_d   = S_FETCH;
         end
         S_JUMP: begin
            pcsrc    = 2'b10;
            pc_write = 1'b1;
            state_d  = S_FETCH;
         end
         default: state_d = S_FETCH;
      endcase
   end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// Randomized bench for multicycle_control_unit: each instruction is expanded
// into its expected per-cycle control word from the instruction-level rules,
// and one compare process checks the DUT word at every falling edge.
module tb_multicycle_control_unit;

   typedef struct packed {
      logic       mem_req;
      logic       mem_write;
      logic       iord;
      logic       ir_write;
      logic       pc_write;
      logic       reg_write;
      logic       regdst;
      logic       memtoreg;
      logic       alusrca;
      logic [1:0] alusrcb;
      logic [1:0] pcsrc;
      logic [2:0] aluop;
      logic       illegal_op;
      logic [3:0] state;
   } ctl_t;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [5:0] opcode = '0;
   logic       zero = 1'b0;
   logic       mem_ready = 1'b0;
   logic       mem_req, mem_write, iord, ir_write, pc_write, reg_write;
   logic       regdst, memtoreg, alusrca, illegal_op;
   logic [1:0] alusrcb, pcsrc;
   logic [2:0] aluop;
   logic [3:0] state;

   int   total = 0;
   int   bad   = 0;
   bit   chk_en = 1'b0;
   ctl_t exp_v;
   ctl_t act;

   multicycle_control_unit #(.PC_INC_SEL(2'b01), .STATE_W(4)) dut (
      .clk(clk), .rst(rst), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
      .mem_req(mem_req), .mem_write(mem_write), .iord(iord), .ir_write(ir_write),
      .pc_write(pc_write), .reg_write(reg_write), .regdst(regdst),
      .memtoreg(memtoreg), .alusrca(alusrca), .alusrcb(alusrcb), .pcsrc(pcsrc),
      .aluop(aluop), .illegal_op(illegal_op), .state(state)
   );

   assign act = {mem_req, mem_write, iord, ir_write, pc_write, reg_write, regdst,
                 memtoreg, alusrca, alusrcb, pcsrc, aluop, illegal_op, state};

   always #5 clk = ~clk;

   // Per-cycle comparison against the model's expected control word.
   always @(negedge clk) begin
      if (chk_en) begin
         total++;
         if (act !== exp_v) begin
            bad++;
            $display("FAIL ctl t=%0t op=%h act=%h (state %0d) exp=%h (state %0d)",
                     $time, opcode, act, act.state, exp_v, exp_v.state);
         end
      end
   end

   task automatic chk(input string nm, input int a, input int e);
      total++;
      if (a !== e) begin
         bad++;
         $display("FAIL %s act=%0d exp=%0d", nm, a, e);
      end
   endtask

   function automatic bit is_legal(input logic [5:0] op);
      if (op inside {6'h23, 6'h2B, 6'h00, 6'h04, 6'h08, 6'h02}) return 1'b1;
`ifdef IMM_LOGIC_EN
      if (op inside {6'h0C, 6'h0D}) return 1'b1;
`endif
      return 1'b0;
   endfunction

   // One clock cycle: apply mem_ready, publish expected word, advance.
   task automatic cyc(input logic mr, input ctl_t e);
      mem_ready = mr;
      exp_v     = e;
      chk_en    = 1'b1;
      @(posedge clk);
      #1;
   endtask

   function automatic logic rbit();
      return 1'($urandom_range(0, 1));
   endfunction

   // Expand one instruction into its expected cycle sequence.
   // wf/wm: memory wait cycles in FETCH and in the data access.
   task automatic run(input logic [5:0] op, input logic z, input int wf, input int wm);
      ctl_t e;
      opcode = op;
      zero   = z;
      // FETCH
      e = '0; e.state = 4'd0; e.mem_req = 1'b1; e.alusrcb = 2'b01;
      for (int i = 0; i < wf; i++) cyc(1'b0, e);
      e.ir_write = 1'b1; e.pc_write = 1'b1;
      cyc(1'b1, e);
      // DECODE
      e = '0; e.state = 4'd1; e.alusrcb = 2'b11;
      if (!is_legal(op)) begin
         e.illegal_op = 1'b1;
         cyc(rbit(), e);
         return;
      end
      cyc(rbit(), e);
      case (op)
         6'h23, 6'h2B: begin
            e = '0; e.state = 4'd2; e.alusrca = 1'b1; e.alusrcb = 2'b10;
            cyc(rbit(), e);
            e = '0; e.mem_req = 1'b1; e.iord = 1'b1;
            if (op == 6'h2B) begin
               e.state = 4'd5; e.mem_write = 1'b1;
            end else begin
               e.state = 4'd3;
            end
            for (int i = 0; i < wm; i++) cyc(1'b0, e);
            cyc(1'b1, e);
            if (op == 6'h23) begin
               e = '0; e.state = 4'd4; e.reg_write = 1'b1; e.memtoreg = 1'b1;
               cyc(rbit(), e);
            end
         end
         6'h00: begin
            e = '0; e.state = 4'd6; e.alusrca = 1'b1; e.aluop = 3'b010;
            cyc(rbit(), e);
            e = '0; e.state = 4'd7; e.reg_write = 1'b1; e.regdst = 1'b1;
            cyc(rbit(), e);
         end
         6'h04: begin
            e = '0; e.state = 4'd8; e.alusrca = 1'b1; e.aluop = 3'b001;
            e.pcsrc = 2'b01; e.pc_write = z;
            cyc(rbit(), e);
         end
         6'h02: begin
            e = '0; e.state = 4'd11; e.pcsrc = 2'b10; e.pc_write = 1'b1;
            cyc(rbit(), e);
         end
         default: begin
            // addi, and (when enabled) andi/ori share the immediate writeback
            e = '0; e.alusrca = 1'b1; e.alusrcb = 2'b10;
            if (op == 6'h08) begin
               e.state = 4'd9; e.aluop = 3'b000;
            end else begin
               e.state = 4'd10; e.aluop = (op == 6'h0D) ? 3'b100 : 3'b011;
            end
            cyc(rbit(), e);
            e = '0; e.state = 4'd12; e.reg_write = 1'b1;
            cyc(rbit(), e);
         end
      endcase
   endtask

   initial begin
      ctl_t rv;
      logic [5:0] ops [0:7];
      int st_log [0:5];
      int rw_log [0:5];
      int mr_log [0:5];
      ops[0] = 6'h23; ops[1] = 6'h2B; ops[2] = 6'h00; ops[3] = 6'h04;
      ops[4] = 6'h08; ops[5] = 6'h02; ops[6] = 6'h0C; ops[7] = 6'h0D;
      rv = '0; rv.mem_req = 1'b1; rv.alusrcb = 2'b01;

      // Reset held with mem_ready high: FETCH word with no IR/PC loads.
      rst = 1'b1; mem_ready = 1'b1; exp_v = rv; chk_en = 1'b1;
      @(posedge clk); @(posedge clk); #1;
      rst = 1'b0;

      // lw with mem_ready tied high: hand-written state trace.
      chk_en = 1'b0; opcode = 6'h23; mem_ready = 1'b1;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         st_log[i] = int'(state); rw_log[i] = int'(reg_write); mr_log[i] = int'(memtoreg);
         @(posedge clk); #1;
      end
      chk("lw_s0", st_log[0], 0); chk("lw_s1", st_log[1], 1);
      chk("lw_s2", st_log[2], 2); chk("lw_s3", st_log[3], 3);
      chk("lw_s4", st_log[4], 4); chk("lw_s5", st_log[5], 0);
      chk("lw_rw3", rw_log[3], 0); chk("lw_rw4", rw_log[4], 1);
      chk("lw_m2r4", mr_log[4], 1); chk("lw_m2r2", mr_log[2], 0);
      // DUT now in DECODE of the next lw; finish it so we are back at FETCH.
      chk_en = 1'b0;
      @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1; @(posedge clk); #1;
      chk("lw_back_fetch", int'(state), 0);

      // Directed plan items through the model.
      run(6'h2B, 1'b0, 0, 3);
      run(6'h00, 1'b0, 1, 0);
      run(6'h04, 1'b1, 0, 0);
      run(6'h04, 1'b0, 2, 0);
      run(6'h0D, 1'b0, 0, 0);
      run(6'h0C, 1'b1, 0, 0);
      run(6'h3F, 1'b0, 0, 0);

      // Reset mid-MEMRD: state collapses with no clock edge.
      begin
         ctl_t e;
         opcode = 6'h23;
         e = '0; e.state = 4'd0; e.mem_req = 1'b1; e.alusrcb = 2'b01;
         e.ir_write = 1'b1; e.pc_write = 1'b1;
         cyc(1'b1, e);
         e = '0; e.state = 4'd1; e.alusrcb = 2'b11;
         cyc(1'b0, e);
         e = '0; e.state = 4'd2; e.alusrca = 1'b1; e.alusrcb = 2'b10;
         cyc(1'b0, e);
         e = '0; e.state = 4'd3; e.mem_req = 1'b1; e.iord = 1'b1;
         cyc(1'b0, e);
         chk_en = 1'b0; mem_ready = 1'b0;
         #2 rst = 1'b1;
         #1;
         chk("rst_state", int'(state), 0);
         chk("rst_mem_write", int'(mem_write), 0);
         chk("rst_reg_write", int'(reg_write), 0);
         chk("rst_mem_req", int'(mem_req), 1);
         chk("rst_iord", int'(iord), 0);
         exp_v = rv; chk_en = 1'b1; mem_ready = 1'b1;
         @(posedge clk); #1;
         rst = 1'b0;
      end

      // Randomized instruction stream.
      for (int n = 0; n < 300; n++) begin
         int k;
         logic [5:0] op;
         k  = int'($urandom_range(0, 9));
         op = (k < 8) ? ops[k] : 6'($urandom_range(0, 63));
         run(op, rbit(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
      end

      chk_en = 1'b0;
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/multicycle_control_unit.md
Name: multicycle_control_unit

Overview:
- Main control FSM for the multicycle MIPS datapath.
- Decodes the IR opcode and sequences fetch, decode, execute, memory and writeback over 3–5 cycles per instruction.
- Drives datapath mux selects and write enables, and supplies the 3-bit aluop consumed by alu_control_unit.
- Sits between the instruction register and the shared datapath; handshakes with the unified instruction/data memory.

Parameters:
- PC_INC_SEL, 2'b01, alusrcb encoding that selects constant 4 for PC increment.
- STATE_W, 4, state register width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- opcode  input  6  IR[31:26], valid from DECODE onward.
- zero  input  1  ALU zero flag, used in BRANCH.
- mem_ready  input  1  memory has completed the current access this cycle.
- mem_req  output  1  memory access request, held until mem_ready.
- mem_write  output  1  access is a write (valid with mem_req).
- iord  output  1  address source: 0 = PC, 1 = ALUOut.
- ir_write  output  1  load IR.
- pc_write  output  1  load PC: unconditional, or branch taken.
- reg_write  output  1  register file write enable.
- regdst  output  1  destination register: 0 = rt, 1 = rd.
- memtoreg  output  1  writeback source: 0 = ALUOut, 1 = MDR.
- alusrca  output  1  ALU A source: 0 = PC, 1 = rs.
- alusrcb  output  2  ALU B source: 00 rt, 01 const 4, 10 sign-extended immediate, 11 sign-extended immediate << 2.
- pcsrc  output  2  PC source: 00 ALU result, 01 ALUOut, 10 jump target.
- aluop  output  3  to alu_control_unit: 000 add, 001 sub, 010 R-type (use funct), 011 and, 100 or.
- illegal_op  output  1  one-cycle pulse on an undefined opcode.
- state  output  STATE_W  current state, for debug and verification.

Behaviour:
- Reset:
  - rst high forces state to FETCH immediately (asynchronous).
  - While rst is high, all outputs are 0 except mem_req = 1 (FETCH) and alusrcb = 01.
  - Reset mid-access abandons the access.
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMRD=3, MEMWB=4, MEMWR=5, RTEX=6, ALUWB=7, BRANCH=8, ADDIEX=9, IMMEX=10, JUMP=11, IMMWB=12.
- Default outputs: every output is 0 in every state unless listed below.
- FETCH:
  - mem_req = 1, iord = 0, alusrca = 0, alusrcb = 01, aluop = 000.
  - ir_write and pc_write = mem_ready (Mealy). PC+4 is loaded in the same cycle the instruction is captured.
  - Stay in FETCH while mem_ready = 0; go to DECODE on mem_ready.
- DECODE:
  - alusrca = 0, alusrcb = 11, aluop = 000 (branch target into ALUOut).
  - Next state by opcode:
    - 0x23 lw or 0x2B sw -> MEMADR
    - 0x00 R-type -> RTEX
    - 0x04 beq -> BRANCH
    - 0x08 addi -> ADDIEX
    - 0x02 j -> JUMP
    - 0x0C andi or 0x0D ori -> IMMEX (optional feature only)
    - anything else -> illegal_op = 1 for this cycle, next state FETCH
- MEMADR: alusrca = 1, alusrcb = 10, aluop = 000. Next state MEMRD for lw, MEMWR for sw.
- MEMRD: mem_req = 1, iord = 1. Hold until mem_ready, then MEMWB.
- MEMWB: reg_write = 1, regdst = 0, memtoreg = 1. Next state FETCH.
- MEMWR:
  - mem_req = 1, mem_write = 1, iord = 1. Hold until mem_ready, then FETCH.
  - mem_write stays asserted for every cycle of the wait.
- RTEX: alusrca = 1, alusrcb = 00, aluop = 010. Next state ALUWB.
- ALUWB: reg_write = 1, regdst = 1, memtoreg = 0. Next state FETCH.
- BRANCH: alusrca = 1, alusrcb = 00, aluop = 001, pcsrc = 01, pc_write = zero. Next state FETCH.
- ADDIEX: alusrca = 1, alusrcb = 10, aluop = 000. Next state IMMWB.
- IMMWB: reg_write = 1, regdst = 0, memtoreg = 0. Next state FETCH.
- JUMP: pcsrc = 10, pc_write = 1. Next state FETCH.
- Cycle counts, excluding memory wait cycles (FETCH and MEMRD/MEMWR each count 1 with zero wait):

  | Instruction | Cycles |
  |---|---|
  | lw | 5 |
  | sw | 4 |
  | R-type | 4 |
  | addi | 4 |
  | beq | 3 |
  | j | 3 |

- mem_ready arriving outside a memory state is ignored.
- States 13–15 are unreachable; if entered, next state is FETCH and all outputs are at their defaults.

Optional Feature:
- Macro IMM_LOGIC_EN.
- Defined:
  - opcodes 0x0C and 0x0D in DECODE go to IMMEX.
  - IMMEX: alusrca = 1, alusrcb = 10, aluop = 011 for andi or 100 for ori. Next state IMMWB.
  - IMMWB is shared with addi.
- Undefined:
  - IMMEX is not generated.
  - 0x0C and 0x0D are illegal: illegal_op pulse, return to FETCH.

Test Plan:
- rst = 1 asserted mid-MEMRD -> state = 0 with no clock edge; mem_write = 0, reg_write = 0; after release, FETCH with mem_req = 1.
- mem_ready tied 1, opcode 0x23 -> states 0,1,2,3,4,0; reg_write = 1 and memtoreg = 1 only in the 5th cycle.
- opcode 0x2B, mem_ready low for 3 cycles in MEMWR -> mem_req = 1 and mem_write = 1 held for 4 cycles, then FETCH; reg_write never asserted.
- opcode 0x00 -> aluop = 010 in RTEX; reg_write = 1 and regdst = 1 in ALUWB.
- opcode 0x04 with zero = 1 -> pc_write = 1, pcsrc = 01, aluop = 001 in BRANCH; repeat with zero = 0 -> pc_write = 0.
- opcode 0x0D -> with IMM_LOGIC_EN, aluop = 100 in IMMEX, then reg_write = 1; without it, illegal_op = 1 for one cycle in DECODE, then FETCH.
